// File: rtl/conv_layer_mem.sv
// conv_layer_mem: two-bank layer memory (L0 64x64, L1 32x32) with engine port and host dump stream.
// Optional DUMP_CHECKSUM_EN adds dump_sum, a running sign-extended sum of accepted dump beats.
module conv_layer_mem #(
    parameter int DATA_W   = 20,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cwr,
    input  logic [11:0]       caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [11:0]       caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    input  logic              dump_start,
    input  logic [2:0]        dump_bank,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [11:0]       dump_addr,
    output logic              dump_last,
    output logic              dump_busy,
    output logic              dump_done,
`ifdef DUMP_CHECKSUM_EN
    output logic [31:0]       dump_sum,
`endif
    output logic              sel_err
);
    localparam int A0 = $clog2(L0_DEPTH);
    localparam int A1 = $clog2(L1_DEPTH);
    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_SEND = 2'd1;
    localparam logic [1:0] D_DONE = 2'd2;

    logic [DATA_W-1:0] l0_mem [L0_DEPTH];
    logic [DATA_W-1:0] l1_mem [L1_DEPTH];
    logic [1:0]        state;
    logic              bank_l1;
    logic              csel_ok, dbank_ok, start_ok, hs, bad_cmd, load_l1;
    logic [11:0]       last_addr, next_addr;
    logic [DATA_W-1:0] next_word;

    assign csel_ok  = csel == SEL_L0 || csel == SEL_L1;
    assign dbank_ok = dump_bank == SEL_L0 || dump_bank == SEL_L1;
    assign start_ok = state == D_IDLE && dump_start && dbank_ok;
    assign bad_cmd  = ((cwr || crd) && !csel_ok) || (state == D_IDLE && dump_start && !dbank_ok);

    always_ff @(posedge clk) begin
        if (cwr && csel == SEL_L0) l0_mem[caddr_wr[A0-1:0]] <= cdata_wr;
        if (cwr && csel == SEL_L1) l1_mem[caddr_wr[A1-1:0]] <= cdata_wr;
    end

    assign cdata_rd = !crd ? '0 :
                      csel == SEL_L0 ? l0_mem[caddr_rd[A0-1:0]] :
                      csel == SEL_L1 ? l1_mem[caddr_rd[A1-1:0]] : '0;

    assign dump_valid = state == D_SEND;
    assign dump_busy  = dump_valid;
    assign dump_done  = state == D_DONE;
    assign hs         = dump_valid && dump_ready;
    assign last_addr  = bank_l1 ? 12'(L1_DEPTH - 1) : 12'(L0_DEPTH - 1);
    assign dump_last  = dump_valid && dump_addr == last_addr;
    // The dump port reads the next word on the loading edge, so a stalled beat is a snapshot.
    assign next_addr  = start_ok ? 12'd0 : dump_addr + 12'd1;
    assign load_l1    = start_ok ? dump_bank == SEL_L1 : bank_l1;
    assign next_word  = load_l1 ? l1_mem[next_addr[A1-1:0]] : l0_mem[next_addr[A0-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= D_IDLE;
            bank_l1   <= 1'b0;
            dump_addr <= '0;
            dump_data <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (bad_cmd) sel_err <= 1'b1;
            if (start_ok) begin
                state     <= D_SEND;
                bank_l1   <= dump_bank == SEL_L1;
                dump_addr <= next_addr;
                dump_data <= next_word;
            end else if (hs && dump_last) begin
                state <= D_DONE;
            end else if (hs) begin
                dump_addr <= next_addr;
                dump_data <= next_word;
            end else if (dump_done) begin
                state <= D_IDLE;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dump_sum <= '0;
        else if (start_ok) dump_sum <= '0;
        else if (hs) dump_sum <= dump_sum + {{(32-DATA_W){dump_data[DATA_W-1]}}, dump_data};
    end
`endif
endmodule

// File: tb/tb_conv_layer_mem.sv
// tb_conv_layer_mem: directed bench for conv_layer_mem; dump beats are checked by a queue scoreboard.
module tb_conv_layer_mem;
    logic        clk = 0, reset_n = 0;
    logic        cwr = 0, crd = 0, dump_start = 0, dump_ready = 0;
    logic [11:0] caddr_wr = 0, caddr_rd = 0;
    logic [19:0] cdata_wr = 0;
    logic [2:0]  csel = 0, dump_bank = 0;
    logic [19:0] cdata_rd, dump_data;
    logic [11:0] dump_addr;
    logic        dump_valid, dump_last, dump_busy, dump_done, sel_err;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] dump_sum;
`endif

    conv_layer_mem dut (
        .clk(clk), .reset_n(reset_n), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .dump_start(dump_start), .dump_bank(dump_bank), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
        .dump_last(dump_last), .dump_busy(dump_busy), .dump_done(dump_done),
`ifdef DUMP_CHECKSUM_EN
        .dump_sum(dump_sum),
`endif
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, done_cnt = 0;
    logic [19:0] m0 [4096];
    logic [19:0] m1 [1024];
    logic [32:0] q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
    logic        stall_prev = 0, last_prev = 0;
    logic [33:0] held;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 0;
            last_prev  = 0;
        end else begin
            if (dump_done || last_prev) chk("done_pulse", 64'(dump_done), 64'(last_prev));
            if (stall_prev) chk("stall_stable", 64'({dump_valid, dump_addr, dump_data, dump_last}), 64'(held));
            if (dump_valid && dump_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 64'({dump_addr, dump_data, dump_last}), 64'h1_FFFF_FFFF);
                else chk("beat", 64'({dump_addr, dump_data, dump_last}), 64'(q.pop_front()));
            end
            stall_prev = dump_valid && !dump_ready;
            held       = {dump_valid, dump_addr, dump_data, dump_last};
            last_prev  = dump_valid && dump_ready && dump_last;
            if (dump_done) done_cnt++;
        end
    end

    task automatic wr(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
        cwr = 1; csel = sel; caddr_wr = a; cdata_wr = d;
        @(posedge clk); #1;
        cwr = 0;
        if (sel == 3'b001) m0[a] = d;
        else if (sel == 3'b011) m1[a[9:0]] = d;
    endtask

    task automatic run_dump(input logic [2:0] bank, input int exp_n, input int stall_at,
                            input int abort_at, input int dup_at);
        int depth = (bank == 3'b011) ? 1024 : 4096;
        int n = 0, sc = 0, d0 = done_cnt;
        for (int i = 0; i < depth; i++)
            q.push_back({12'(i), (bank == 3'b011) ? m1[i % 1024] : m0[i], i == depth - 1});
        dump_bank = bank; dump_start = 1; dump_ready = 1;
        @(posedge clk); #1;
        dump_start = 0;
        chk("busy_after_start", 64'(dump_busy), 64'd1);
        while (!dump_done && n < exp_n + 20) begin
            cwr = 0; dump_start = 0;
            if (dump_addr == 12'(abort_at) && abort_at >= 0) begin
                reset_n = 0; #1;
                chk("abort_outputs", 64'({dump_valid, dump_last, dump_busy, dump_done, sel_err, dump_addr, dump_data}), 64'd0);
                q.delete();
                repeat (3) @(posedge clk);
                #1 reset_n = 1;
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
                chk("abort_idle", 64'({dump_busy, dump_valid}), 64'd0);
                return;
            end
            if (dup_at >= 0 && dump_addr == 12'(dup_at)) begin dump_start = 1; dump_bank = 3'b011; end
            if (stall_at >= 0 && dump_addr == 12'(stall_at) && sc < 5) begin
                dump_ready = 0;
                if (sc == 0) begin
                    cwr = 1; csel = 3'b001; caddr_wr = 12'(stall_at); cdata_wr = 20'hFFFFF;
                    m0[stall_at] = 20'hFFFFF;
                end
                sc++;
            end else dump_ready = 1;
            @(posedge clk); #1;
            n++;
        end
        cwr = 0; dump_start = 0;
        chk("dump_cycles", 64'(n), 64'(exp_n));
        @(posedge clk); #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("idle_after_done", 64'({dump_done, dump_busy}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_outputs", 64'({dump_valid, dump_last, dump_busy, dump_done, sel_err, dump_addr, dump_data}), 64'd0);
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        // Engine write/read, including read-during-write returning old data
        wr(3'b001, 12'h041, 20'h01310);
        crd = 1; csel = 3'b001; caddr_rd = 12'h041;
        cwr = 1; caddr_wr = 12'h041; cdata_wr = 20'h02222;
        @(negedge clk) chk("rd_l0_old", 64'(cdata_rd), 64'h01310);
        @(posedge clk); #1 cwr = 0; m0[12'h041] = 20'h02222;
        @(negedge clk) chk("rd_l0_new", 64'(cdata_rd), 64'h02222);
        @(posedge clk); #1 crd = 0;
        wr(3'b011, 12'hC05, 20'h0ABCD);
        crd = 1; csel = 3'b011; caddr_rd = 12'h005;
        @(negedge clk) chk("rd_l1_fold", 64'(cdata_rd), 64'h0ABCD);
        chk("sel_err_clean", 64'(sel_err), 64'd0);
        @(posedge clk); #1 crd = 0;
        // Invalid bank codes
        wr(3'b010, 12'h041, 20'h05555);
        @(negedge clk) chk("sel_err_wr", 64'(sel_err), 64'd1);
        @(posedge clk); #1 crd = 1; csel = 3'b001; caddr_rd = 12'h041;
        @(negedge clk) chk("rd_after_bad_wr", 64'(cdata_rd), 64'h02222);
        @(posedge clk); #1 csel = 3'b000;
        @(negedge clk) chk("rd_bad_sel", 64'(cdata_rd), 64'd0);
        @(posedge clk); #1 crd = 0; csel = 3'b001;
        @(negedge clk) chk("rd_no_strobe", 64'(cdata_rd), 64'd0);
        chk("sel_err_sticky", 64'(sel_err), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4096; i++) wr(3'b001, 12'(i), 20'((i * 37 + 11) & 20'hFFFFF));
        for (int i = 0; i < 1024; i++) wr(3'b011, 12'(i), 20'(i));
        // Full-rate L1 dump
        run_dump(3'b011, 1024, -1, -1, -1);
        // L0 dump: stall on beat 7 with engine write to it, ignored dump_start at beat 50
        run_dump(3'b001, 4101, 7, -1, 50);
        // Reset mid-dump, then invalid dump bank, then a clean dump from address 0
        run_dump(3'b001, 4096, -1, 100, -1);
        chk("sel_err_reset", 64'(sel_err), 64'd0);
        dump_bank = 3'b111; dump_start = 1;
        @(posedge clk); #1 dump_start = 0;
        chk("sel_err_dump", 64'(sel_err), 64'd1);
        chk("bad_dump_idle", 64'({dump_busy, dump_valid}), 64'd0);
        run_dump(3'b001, 4096, -1, -1, -1);
`ifdef DUMP_CHECKSUM_EN
        for (int i = 0; i < 1024; i++) wr(3'b011, 12'(i), 20'hFFFFF);
        run_dump(3'b011, 1024, -1, -1, -1);
        chk("dump_sum", 64'(dump_sum), 64'hFFFFFC00);
`endif
        repeat (2) @(posedge clk);
        #1 chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
